// File: rtl/frame_block_fetcher.sv
// frame_block_fetcher
// Reads one BLOCK_SIZE x BLOCK_SIZE pixel block out of raster-ordered frame
// memory, clamping out-of-frame coordinates to the nearest edge pixel, and
// presents the assembled block on a valid/ready output.

module frame_block_fetcher #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int BLOCK_SIZE   = 8,
    parameter int PIXEL_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 19,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [9:0]                                   block_x,
    input  logic [9:0]                                   block_y,
    output logic                                         busy,
    output logic [ADDR_WIDTH-1:0]                        mem_addr,
    output logic                                         mem_re,
    input  logic [PIXEL_WIDTH-1:0]                       mem_rdata,
    output logic [BLOCK_SIZE*BLOCK_SIZE*PIXEL_WIDTH-1:0] blk,
    output logic                                         blk_valid,
    input  logic                                         blk_ready
);

    localparam int NUM_PIX  = BLOCK_SIZE * BLOCK_SIZE;
    localparam int IDX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int BLK_BITS = NUM_PIX * PIXEL_WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Coordinate arithmetic is carried in 20 bits so that a block far outside
    // the frame still produces an untruncated position before clamping.
    localparam logic [19:0] BS20 = 20'(BLOCK_SIZE);
    localparam logic [19:0] FW20 = 20'(FRAME_WIDTH);
    localparam logic [19:0] FH20 = 20'(FRAME_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUTPUT
    } state_t;

    state_t state_q, state_d;

    logic [9:0]            blockX_q, blockX_d;
    logic [9:0]            blockY_q, blockY_d;
    logic [IDX_W-1:0]      curIdx_q, curIdx_d;
    logic                  memRe_q, memRe_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [BLK_BITS-1:0]   blk_q;

    logic                  pipeValid_q [MEM_LATENCY];
    logic [IDX_W-1:0]      pipeIdx_q   [MEM_LATENCY];
    logic                  capValid;
    logic [IDX_W-1:0]      capIdx;

    // Frame address of pixel idx of block (bx, by) with edge clamping per axis.
    function automatic logic [ADDR_WIDTH-1:0] pixelAddr(
        input logic [9:0]       bx,
        input logic [9:0]       by,
        input logic [IDX_W-1:0] idx
    );
        logic [19:0] rowPos;
        logic [19:0] colPos;
        logic [31:0] linear;
        rowPos = {10'd0, by} * BS20 + (20'(idx) / BS20);
        colPos = {10'd0, bx} * BS20 + (20'(idx) % BS20);
        if (rowPos > FH20 - 20'd1) begin
            rowPos = FH20 - 20'd1;
        end
        if (colPos > FW20 - 20'd1) begin
            colPos = FW20 - 20'd1;
        end
        linear = {12'd0, rowPos} * {12'd0, FW20} + {12'd0, colPos};
        return ADDR_WIDTH'(linear);
    endfunction

    // The oldest entry of the return-tracking pipeline names the slot that
    // the current mem_rdata belongs to.
    assign capValid = pipeValid_q[MEM_LATENCY-1];
    assign capIdx   = pipeIdx_q[MEM_LATENCY-1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the block is complete only once the last pixel has
    // actually returned, not when its read was issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (curIdx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (capValid && (capIdx == LAST_IDX)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (blk_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the first read is prepared from the raw inputs while the
    // start is accepted, so the read strobe is high from the very next edge.
    always_comb begin
        blockX_d  = blockX_q;
        blockY_d  = blockY_q;
        curIdx_d  = curIdx_q;
        memRe_d   = 1'b0;
        memAddr_d = memAddr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    blockX_d  = block_x;
                    blockY_d  = block_y;
                    curIdx_d  = '0;
                    memRe_d   = 1'b1;
                    memAddr_d = pixelAddr(block_x, block_y, '0);
                end
            end
            FETCH: begin
                if (curIdx_q != LAST_IDX) begin
                    curIdx_d  = curIdx_q + IDX_ONE;
                    memRe_d   = 1'b1;
                    memAddr_d = pixelAddr(blockX_q, blockY_q, curIdx_q + IDX_ONE);
                end
            end
            default: begin
            end
        endcase
    end

    // Issue-side registers: latched coordinates, pixel counter and the
    // registered read strobe/address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blockX_q  <= '0;
            blockY_q  <= '0;
            curIdx_q  <= '0;
            memRe_q   <= 1'b0;
            memAddr_q <= '0;
        end else begin
            blockX_q  <= blockX_d;
            blockY_q  <= blockY_d;
            curIdx_q  <= curIdx_d;
            memRe_q   <= memRe_d;
            memAddr_q <= memAddr_d;
        end
    end

    // Return-tracking pipeline: each issued read travels MEM_LATENCY stages
    // alongside the memory so its data lands in the right slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MEM_LATENCY; k++) begin
                pipeValid_q[k] <= 1'b0;
                pipeIdx_q[k]   <= '0;
            end
        end else begin
            pipeValid_q[0] <= memRe_q;
            pipeIdx_q[0]   <= curIdx_q;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pipeValid_q[k] <= pipeValid_q[k-1];
                pipeIdx_q[k]   <= pipeIdx_q[k-1];
            end
        end
    end

    // Block assembly: capture runs regardless of state so returns straddling
    // the end of issuing are still written; contents persist after transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q <= '0;
        end else if (capValid) begin
            blk_q[int'(capIdx)*PIXEL_WIDTH +: PIXEL_WIDTH] <= mem_rdata;
        end
    end

    assign busy      = (state_q != IDLE);
    assign blk_valid = (state_q == OUTPUT);
    assign mem_re    = memRe_q;
    assign mem_addr  = memAddr_q;
    assign blk       = blk_q;

endmodule

// File: tb/tb_frame_block_fetcher.sv
// tb_frame_block_fetcher
// Directed bench for frame_block_fetcher: two instances (memory latency 1
// and 3) share stimulus, each fed by a memory that returns addr[7:0].

module tb_frame_block_fetcher;

    localparam int AW = 19;
    localparam int BB = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [9:0]    blockX;
    logic [9:0]    blockY;
    logic          blkReady;

    logic          busy1, memRe1, blkValid1;
    logic [AW-1:0] memAddr1;
    logic [7:0]    memRdata1;
    logic [BB-1:0] blk1;

    logic          busy3, memRe3, blkValid3;
    logic [AW-1:0] memAddr3;
    logic [7:0]    memRdata3;
    logic [BB-1:0] blk3;

    logic [AW-1:0] rd1;
    logic [AW-1:0] rd3 [3];

    int checkCount = 0;
    int errorCount = 0;

    int reCnt1, reCnt3, firstRe1, firstRe3, lastRe1, lastRe3, rise1, rise3;
    int addrLog1 [64];
    int addrLog3 [64];

    frame_block_fetcher #(.MEM_LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .block_x   (blockX),
        .block_y   (blockY),
        .busy      (busy1),
        .mem_addr  (memAddr1),
        .mem_re    (memRe1),
        .mem_rdata (memRdata1),
        .blk       (blk1),
        .blk_valid (blkValid1),
        .blk_ready (blkReady)
    );

    frame_block_fetcher #(.MEM_LATENCY(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .block_x   (blockX),
        .block_y   (blockY),
        .busy      (busy3),
        .mem_addr  (memAddr3),
        .mem_re    (memRe3),
        .mem_rdata (memRdata3),
        .blk       (blk3),
        .blk_valid (blkValid3),
        .blk_ready (blkReady)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory models: data for an address sampled at one edge is on the bus
    // for sampling LATENCY edges later.
    always @(posedge clk) begin
        rd1    <= memAddr1;
        rd3[0] <= memAddr3;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    assign memRdata1 = rd1[7:0];
    assign memRdata3 = rd3[2][7:0];

    // Run-time bound so a stuck design still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [BB-1:0] observed,
                               input logic [BB-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int refAddr(input int bx, input int by, input int n);
        int r;
        int c;
        r = by * 8 + n / 8;
        c = bx * 8 + n % 8;
        if (r > 479) r = 479;
        if (c > 639) c = 639;
        return r * 640 + c;
    endfunction

    function automatic logic [BB-1:0] buildBlock(input int bx, input int by);
        logic [BB-1:0] b;
        int a;
        b = '0;
        for (int n = 0; n < 64; n++) begin
            a = refAddr(bx, by, n);
            b[n*8 +: 8] = a[7:0];
        end
        return b;
    endfunction

    // One full fetch on both instances with blk_ready held high, logging
    // every read and the cycle (edge index after the accepting edge) of
    // each event.
    task automatic applyStimulus(input logic [9:0] bx, input logic [9:0] by);
        reCnt1 = 0; reCnt3 = 0;
        firstRe1 = -1; firstRe3 = -1; lastRe1 = -1; lastRe3 = -1;
        rise1 = -1; rise3 = -1;
        @(negedge clk);
        start = 1'b1; blockX = bx; blockY = by;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (memRe1) begin
                if (reCnt1 < 64) addrLog1[reCnt1] = int'(memAddr1);
                if (firstRe1 < 0) firstRe1 = k;
                lastRe1 = k;
                reCnt1++;
            end
            if (memRe3) begin
                if (reCnt3 < 64) addrLog3[reCnt3] = int'(memAddr3);
                if (firstRe3 < 0) firstRe3 = k;
                lastRe3 = k;
                reCnt3++;
            end
            if (blkValid1 && rise1 < 0) rise1 = k;
            if (blkValid3 && rise3 < 0) rise3 = k;
            if (rise1 >= 0 && rise3 >= 0 && !busy1 && !busy3) break;
        end
    endtask

    // Common checks after a fetch: counts, timing, address sequence, data.
    task automatic verifyFetch(input string tag, input int bx, input int by);
        int bad1;
        int bad3;
        logic [BB-1:0] expBlk;
        bad1 = 0; bad3 = 0;
        expBlk = buildBlock(bx, by);
        checkOutput({tag, " reCount1"}, reCnt1, 64);
        checkOutput({tag, " firstRe1"}, firstRe1, 1);
        checkOutput({tag, " lastRe1"}, lastRe1, 64);
        checkOutput({tag, " validRise1"}, rise1, 66);
        checkOutput({tag, " reCount3"}, reCnt3, 64);
        checkOutput({tag, " lastRe3"}, lastRe3, 64);
        checkOutput({tag, " validRise3"}, rise3, 68);
        for (int n = 0; n < 64; n++) begin
            if (addrLog1[n] != refAddr(bx, by, n)) bad1++;
            if (addrLog3[n] != refAddr(bx, by, n)) bad3++;
        end
        checkOutput({tag, " addrSeq1 bad"}, bad1, 0);
        checkOutput({tag, " addrSeq3 bad"}, bad3, 0);
        checkOutput({tag, " blk1"}, blk1, expBlk);
        checkOutput({tag, " blk3"}, blk3, expBlk);
    endtask

    initial begin
        int waitCnt;
        int validLow;
        int blkChange;
        int reSeen;
        int cnt;
        logic [BB-1:0] snap;
        logic [BB-1:0] allFF;

        reset = 1'b1; start = 1'b0; blockX = '0; blockY = '0; blkReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy1, 0);
        checkOutput("reset mem_addr", memAddr1, 0);
        checkOutput("reset mem_re", memRe1, 0);
        checkOutput("reset blk", blk1, 0);
        checkOutput("reset blk_valid", blkValid1, 0);
        @(negedge clk);
        reset = 1'b0;
        blkReady = 1'b1;

        // Block (0,0): plain in-frame fetch.
        applyStimulus(10'd0, 10'd0);
        verifyFetch("b00", 0, 0);
        checkOutput("b00 addr[0]", addrLog1[0], 0);
        checkOutput("b00 addr[7]", addrLog1[7], 7);
        checkOutput("b00 addr[8]", addrLog1[8], 640);
        checkOutput("b00 addr[63]", addrLog1[63], 4487);
        checkOutput("b00 pix(1,2)", blk1[(1*8+2)*8 +: 8], 8'h82);

        // Block (79,59): last in-frame block, no clamping.
        applyStimulus(10'd79, 10'd59);
        verifyFetch("b7959", 79, 59);
        checkOutput("b7959 first addr", addrLog1[0], 302712);
        checkOutput("b7959 last addr", addrLog1[63], 307199);
        checkOutput("b7959 pix(7,7)", blk1[63*8 +: 8], 8'hFF);

        // Block (80,60): entirely outside, every read clamps to the corner.
        applyStimulus(10'd80, 10'd60);
        verifyFetch("b8060", 80, 60);
        cnt = 0;
        for (int n = 0; n < 64; n++) begin
            if (addrLog1[n] != 307199) cnt++;
        end
        checkOutput("b8060 corner addrs bad", cnt, 0);
        allFF = {64{8'hFF}};
        checkOutput("b8060 all FF", blk1, allFF);

        // Block (1,0): latency-3 instance against hand addresses and the
        // latency-1 result.
        applyStimulus(10'd1, 10'd0);
        verifyFetch("b10", 1, 0);
        checkOutput("b10 lat3 addr[0]", addrLog3[0], 8);
        checkOutput("b10 lat3 addr[7]", addrLog3[7], 15);
        checkOutput("b10 lat3 equals lat1", blk3, blk1);

        // Back-pressure: hold ready low in OUTPUT and pulse an ignored start.
        blkReady = 1'b0;
        @(negedge clk);
        start = 1'b1; blockX = 10'd2; blockY = 10'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitCnt = 0;
        while (!blkValid1 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("hold reached valid", blkValid1, 1);
        snap = blk1;
        checkOutput("hold blk data", snap, buildBlock(2, 3));
        validLow = 0; blkChange = 0; reSeen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                start = 1'b1; blockX = 10'd5; blockY = 10'd5;
            end
            if (c == 5) start = 1'b0;
            if (!blkValid1) validLow++;
            if (blk1 !== snap) blkChange++;
            if (memRe1 || memRe3) reSeen++;
        end
        checkOutput("hold valid dropped", validLow, 0);
        checkOutput("hold blk changed", blkChange, 0);
        checkOutput("hold mem_re seen", reSeen, 0);
        checkOutput("hold valid3", blkValid3, 1);
        blkReady = 1'b1;
        @(negedge clk);
        checkOutput("after xfer busy1", busy1, 0);
        checkOutput("after xfer valid1", blkValid1, 0);
        checkOutput("after xfer busy3", busy3, 0);
        checkOutput("after xfer blk kept", blk1, snap);
        reSeen = 0;
        repeat (80) begin
            @(negedge clk);
            if (memRe1 || memRe3 || busy1 || busy3) reSeen++;
        end
        checkOutput("ignored start activity", reSeen, 0);

        // Reset in the middle of issuing, then a clean fetch.
        @(negedge clk);
        start = 1'b1; blockX = 10'd0; blockY = 10'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cnt = memRe1 ? 1 : 0;
        waitCnt = 0;
        while (cnt < 30 && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
            if (memRe1) cnt++;
        end
        checkOutput("midreset reached 30 reads", cnt, 30);
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", busy1, 0);
        checkOutput("midreset mem_re", memRe1, 0);
        checkOutput("midreset blk", blk1, 0);
        checkOutput("midreset blk_valid", blkValid1, 0);
        @(negedge clk);
        reset = 1'b0;
        reSeen = 0;
        repeat (100) begin
            @(negedge clk);
            if (blkValid1 || blkValid3 || memRe1 || memRe3) reSeen++;
        end
        checkOutput("postreset spurious activity", reSeen, 0);
        applyStimulus(10'd0, 10'd0);
        verifyFetch("postreset b00", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
